// File: rtl/change_dispenser.sv
// Greedy coin change dispenser: pays a refund from three finite coin tubes,
// one coin per cycle, and reports any unpaid remainder.
module change_dispenser #(
  parameter logic [7:0] COIN_A   = 8'd10,
  parameter logic [7:0] COIN_B   = 8'd5,
  parameter logic [7:0] COIN_C   = 8'd1,
  parameter logic [7:0] INIT_CNT = 8'd20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refund_valid,
  input  logic [7:0] refund_amt,
  input  logic       refill,
  output logic       ready,
  output logic       coin_valid,
  output logic [7:0] coin_value,
  output logic       done,
  output logic       short_pay,
  output logic [7:0] short_amt,
  output logic [7:0] inv_a,
  output logic [7:0] inv_b,
  output logic [7:0] inv_c
);

  typedef enum logic [1:0] {IDLE = 2'd0, PAY = 2'd1, DONE = 2'd2} state_t;
  typedef enum logic [1:0] {SEL_NONE = 2'd0, SEL_A = 2'd1, SEL_B = 2'd2, SEL_C = 2'd3} sel_t;

  state_t     state, state_nxt;
  sel_t       sel;
  logic [7:0] remain, remain_nxt;
  logic [7:0] inv_a_nxt, inv_b_nxt, inv_c_nxt;
  logic [7:0] coin_value_nxt, short_amt_nxt;
  logic       ready_nxt, coin_valid_nxt, done_nxt, short_pay_nxt;

  // Largest denomination that still fits in the remainder and is in stock.
  function automatic sel_t greedy_pick(input logic [7:0] rem, input logic [7:0] ca,
                                       input logic [7:0] cb, input logic [7:0] cc);
    if (ca != 8'd0 && COIN_A <= rem) return SEL_A;
    if (cb != 8'd0 && COIN_B <= rem) return SEL_B;
    if (cc != 8'd0 && COIN_C <= rem) return SEL_C;
    return SEL_NONE;
  endfunction

  assign sel = greedy_pick(remain, inv_a, inv_b, inv_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      remain     <= 8'd0;
      ready      <= 1'b1;
      coin_valid <= 1'b0;
      coin_value <= 8'd0;
      done       <= 1'b0;
      short_pay  <= 1'b0;
      short_amt  <= 8'd0;
      inv_a      <= INIT_CNT;
      inv_b      <= INIT_CNT;
      inv_c      <= INIT_CNT;
    end else begin
      state      <= state_nxt;
      remain     <= remain_nxt;
      ready      <= ready_nxt;
      coin_valid <= coin_valid_nxt;
      coin_value <= coin_value_nxt;
      done       <= done_nxt;
      short_pay  <= short_pay_nxt;
      short_amt  <= short_amt_nxt;
      inv_a      <= inv_a_nxt;
      inv_b      <= inv_b_nxt;
      inv_c      <= inv_c_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (refund_valid) state_nxt = PAY;
      PAY:     if (sel == SEL_NONE) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    remain_nxt     = remain;
    inv_a_nxt      = inv_a;
    inv_b_nxt      = inv_b;
    inv_c_nxt      = inv_c;
    coin_valid_nxt = 1'b0;
    coin_value_nxt = 8'd0;
    done_nxt       = 1'b0;
    short_pay_nxt  = short_pay;
    short_amt_nxt  = short_amt;
    ready_nxt      = (state_nxt == IDLE);
    case (state)
      IDLE: begin
        // Refill lands before the payout starts, so a same-cycle refund sees full tubes.
        if (refill) begin
          inv_a_nxt = INIT_CNT;
          inv_b_nxt = INIT_CNT;
          inv_c_nxt = INIT_CNT;
        end
        if (refund_valid) begin
          remain_nxt    = refund_amt;
          short_pay_nxt = 1'b0;
          short_amt_nxt = 8'd0;
        end
      end
      PAY: begin
        case (sel)
          SEL_A: begin
            coin_valid_nxt = 1'b1;
            coin_value_nxt = COIN_A;
            remain_nxt     = remain - COIN_A;
            inv_a_nxt      = inv_a - 8'd1;
          end
          SEL_B: begin
            coin_valid_nxt = 1'b1;
            coin_value_nxt = COIN_B;
            remain_nxt     = remain - COIN_B;
            inv_b_nxt      = inv_b - 8'd1;
          end
          SEL_C: begin
            coin_valid_nxt = 1'b1;
            coin_value_nxt = COIN_C;
            remain_nxt     = remain - COIN_C;
            inv_c_nxt      = inv_c - 8'd1;
          end
          default: begin
            done_nxt      = 1'b1;
            short_pay_nxt = (remain != 8'd0);
            short_amt_nxt = remain;
          end
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized scoreboard bench for change_dispenser: a greedy payout model
// predicts each coin and done event; a monitor pops and compares them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       refund_valid, refill;
  logic [7:0] refund_amt;
  logic       ready, coin_valid, done, short_pay;
  logic [7:0] coin_value, short_amt, inv_a, inv_b, inv_c;

  logic       r2_valid, r2_refill;
  logic [7:0] r2_amt;
  logic       ready2, coin_valid2, done2, short_pay2;
  logic [7:0] coin_value2, short_amt2, inv_a2, inv_b2, inv_c2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  change_dispenser dut (
    .clk(clk), .reset(reset), .refund_valid(refund_valid), .refund_amt(refund_amt),
    .refill(refill), .ready(ready), .coin_valid(coin_valid), .coin_value(coin_value),
    .done(done), .short_pay(short_pay), .short_amt(short_amt),
    .inv_a(inv_a), .inv_b(inv_b), .inv_c(inv_c)
  );

  change_dispenser #(.INIT_CNT(8'd2)) dut2 (
    .clk(clk), .reset(reset), .refund_valid(r2_valid), .refund_amt(r2_amt),
    .refill(r2_refill), .ready(ready2), .coin_valid(coin_valid2), .coin_value(coin_value2),
    .done(done2), .short_pay(short_pay2), .short_amt(short_amt2),
    .inv_a(inv_a2), .inv_b(inv_b2), .inv_c(inv_c2)
  );

  typedef struct {
    bit is_done;
    int value;
    int sp;
    int sa;
    int ia;
    int ib;
    int ic;
  } ev_t;

  ev_t q[$];
  ev_t e;
  int  denom[3] = '{10, 5, 1};
  int  m_inv[3];
  int  m_sp, m_sa;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: pay greedily from the largest denomination down, limited by stock.
  function automatic int model_refund(input int amt);
    int rem = amt;
    int n = 0;
    ev_t ev;
    for (int i = 0; i < 3; i++) begin
      while (rem >= denom[i] && m_inv[i] > 0) begin
        ev = '{is_done: 0, value: denom[i], sp: 0, sa: 0, ia: 0, ib: 0, ic: 0};
        q.push_back(ev);
        rem -= denom[i];
        m_inv[i]--;
        n++;
      end
    end
    m_sp = (rem != 0) ? 1 : 0;
    m_sa = rem;
    ev = '{is_done: 1, value: 0, sp: m_sp, sa: m_sa, ia: m_inv[0], ib: m_inv[1], ic: m_inv[2]};
    q.push_back(ev);
    return n;
  endfunction

  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      if (coin_valid || done) begin
        if (q.size() == 0) begin
          chk("unexpected_event", int'(coin_valid) + 2 * int'(done), 0);
        end else begin
          e = q.pop_front();
          if (!e.is_done) begin
            chk("coin_valid", int'(coin_valid), 1);
            chk("coin_value", int'(coin_value), e.value);
            chk("done_during_coin", int'(done), 0);
          end else begin
            chk("done", int'(done), 1);
            chk("coin_at_done", int'(coin_valid), 0);
            chk("short_pay", int'(short_pay), e.sp);
            chk("short_amt", int'(short_amt), e.sa);
            chk("inv_a", int'(inv_a), e.ia);
            chk("inv_b", int'(inv_b), e.ib);
            chk("inv_c", int'(inv_c), e.ic);
          end
        end
      end else begin
        chk("coin_value_idle", int'(coin_value), 0);
      end
    end
  end

  // Called at a negedge; returns at a negedge with the DUT back in IDLE.
  task automatic do_refund(input int amt, input bit rf, input bit noise);
    int w = 0;
    int n, cycles;
    bit seen = 0;
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!ready) begin
      chk("ready_timeout", int'(ready), 1);
      return;
    end
    refund_valid = 1'b1;
    refund_amt   = amt[7:0];
    refill       = rf;
    if (rf) m_inv = '{20, 20, 20};
    n = model_refund(amt);
    @(posedge clk);
    #1;
    refund_valid = 1'b0;
    refill       = 1'b0;
    refund_amt   = 8'($urandom);
    cycles = 0;
    while (cycles < 100) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        refund_valid = 1'b0;
        refill       = 1'b0;
        break;
      end
      cycles++;
      if (cycles == 1) begin
        chk("short_pay_cleared", int'(short_pay), 0);
        chk("short_amt_cleared", int'(short_amt), 0);
        chk("ready_busy", int'(ready), 0);
      end
      if (noise && $urandom_range(0, 2) == 0) begin
        refund_valid = 1'b1;
        refund_amt   = 8'($urandom_range(1, 255));
        refill       = 1'($urandom);
      end else begin
        refund_valid = 1'b0;
        refill       = 1'b0;
      end
    end
    chk("done_seen", int'(seen), 1);
    chk("done_latency", cycles, n + 1);
    @(negedge clk);
    chk("ready_after_done", int'(ready), 1);
    chk("short_pay_hold", int'(short_pay), m_sp);
    chk("short_amt_hold", int'(short_amt), m_sa);
  endtask

  task automatic refund2(input int amt, input int exp_coins[$], input int exp_sa,
                         input int exp_inv);
    int got[$];
    int k = 0;
    r2_valid = 1'b1;
    r2_amt   = amt[7:0];
    @(posedge clk);
    #1;
    r2_valid = 1'b0;
    while (!done2 && k < 40) begin
      @(negedge clk);
      if (coin_valid2) got.push_back(int'(coin_value2));
      k++;
    end
    chk("dut2_done", int'(done2), 1);
    chk("dut2_coin_count", got.size(), exp_coins.size());
    for (int i = 0; i < exp_coins.size() && i < got.size(); i++)
      chk("dut2_coin_value", got[i], exp_coins[i]);
    chk("dut2_short_pay", int'(short_pay2), (exp_sa != 0) ? 1 : 0);
    chk("dut2_short_amt", int'(short_amt2), exp_sa);
    chk("dut2_inv_a", int'(inv_a2), exp_inv);
    chk("dut2_inv_b", int'(inv_b2), exp_inv);
    chk("dut2_inv_c", int'(inv_c2), exp_inv);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int amt;
    reset = 1'b1;
    refund_valid = 1'b0; refill = 1'b0; refund_amt = 8'd0;
    r2_valid = 1'b0; r2_refill = 1'b0; r2_amt = 8'd0;
    m_inv = '{20, 20, 20};
    m_sp = 0; m_sa = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_coin_valid", int'(coin_valid), 0);
    chk("rst_coin_value", int'(coin_value), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_short_pay", int'(short_pay), 0);
    chk("rst_short_amt", int'(short_amt), 0);
    chk("rst_inv_a", int'(inv_a), 20);
    chk("rst_inv_b", int'(inv_b), 20);
    chk("rst_inv_c", int'(inv_c), 20);

    do_refund(37, 0, 0);
    chk("r37_inv_a", int'(inv_a), 17);
    chk("r37_inv_b", int'(inv_b), 19);
    chk("r37_inv_c", int'(inv_c), 18);
    do_refund(0, 0, 0);
    do_refund(20, 0, 1);

    // Reset after the first coin must abort the refund and reload the tubes.
    refund_valid = 1'b1; refund_amt = 8'd37; refill = 1'b1;
    m_inv = '{20, 20, 20};
    void'(model_refund(37));
    @(posedge clk);
    #1 refund_valid = 1'b0; refill = 1'b0;
    for (int i = 0; i < 5 && !coin_valid; i++) @(negedge clk);
    chk("abort_first_coin", int'(coin_valid), 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    m_inv = '{20, 20, 20};
    m_sp = 0; m_sa = 0;
    @(negedge clk);
    chk("abort_ready", int'(ready), 1);
    chk("abort_coin_valid", int'(coin_valid), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_inv_a", int'(inv_a), 20);
    chk("abort_inv_b", int'(inv_b), 20);
    chk("abort_inv_c", int'(inv_c), 20);
    repeat (10) @(negedge clk);

    for (int t = 0; t < 40; t++) begin
      amt = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 90));
      do_refund(amt, ($urandom_range(0, 3) == 0), 1'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    chk("scoreboard_drained", q.size(), 0);

    refund2(35, '{10, 10, 5, 5, 1, 1}, 3, 0);
    r2_refill = 1'b1;
    @(posedge clk);
    #1 r2_refill = 1'b0;
    @(negedge clk);
    chk("dut2_refill_inv_a", int'(inv_a2), 2);
    refund2(16, '{10, 5, 1}, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
